// File: rtl/sram_burst_ctrl.sv
// Burst command to single-port SRAM pin sequencer with a 2-entry read skid FIFO.
// Optional macro SRAM_BURST_CTRL_RD_BYPASS_EN: read words skip the empty FIFO combinationally.
module sram_burst_ctrl #(
  parameter int NUM_WORD = 1024,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              CEB,
  output logic              WEB,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_nxt;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              rptr_q, rptr_d, wptr_q, wptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wr_fire, pop, pop_fifo, push, issue, byp, last;
  logic [2:0]        used;

  always_comb begin
    wr_fire = (state_q == WRITE) && wr_valid;
`ifdef SRAM_BURST_CTRL_RD_BYPASS_EN
    byp = (cnt_q == 2'd0) && inflight_q;
`else
    byp = 1'b0;
`endif
    rd_valid = (cnt_q != 2'd0) || byp;
    rd_data  = byp ? Q : fifo_q[rptr_q];
    pop      = rd_valid && rd_ready;
    pop_fifo = pop && (cnt_q != 2'd0);
    // Credit: words buffered plus the one in flight, net of this cycle's pop.
    used     = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    issue    = (state_q == READ) && (rem_q != '0) && (used < 3'd2);
    push     = inflight_q && !(byp && rd_ready);
    ptr_nxt  = (ptr_q == ADDR_W'(NUM_WORD - 1)) ? '0 : ptr_q + ADDR_W'(1);
    last     = (rem_q == LEN_W'(1));

    CEB       = !(wr_fire || issue);
    WEB       = !wr_fire;
    A         = ptr_q;
    D         = wr_fire ? wr_data : '0;
    cmd_ready = (state_q == IDLE);
    wr_ready  = (state_q == WRITE);
    busy      = (state_q != IDLE);
    done      = done_q;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    inflight_d = issue;
    fifo_d     = fifo_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop_fifo};
    case (state_q)
      IDLE: if (cmd_valid) begin
        ptr_d = cmd_addr;
        rem_d = cmd_len;
        if (cmd_len == '0) done_d = 1'b1;
        else state_d = cmd_we ? WRITE : READ;
      end
      WRITE: if (wr_fire) begin
        ptr_d = ptr_nxt;
        rem_d = rem_q - LEN_W'(1);
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      READ: if (issue) begin
        ptr_d = ptr_nxt;
        rem_d = rem_q - LEN_W'(1);
        if (last) state_d = DRAIN;
      end
      DRAIN: if (!inflight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (push) begin
      fifo_d[wptr_q] = Q;
      wptr_d         = ~wptr_q;
    end
    if (pop_fifo) rptr_d = ~rptr_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      fifo_q     <= '{default: '0};
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      fifo_q     <= fifo_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Bursts longer than the array would overwrite their own start.
  always_ff @(posedge CLK) begin
    if (!RST && cmd_valid && cmd_ready) assert (cmd_len <= LEN_W'(NUM_WORD));
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: SRAM pin model, shadow memory reference and pin/stream monitors.
module tb_sram_burst_ctrl;
  localparam int NW = 1024;
`ifdef SRAM_BURST_CTRL_RD_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic CLK = 0, RST = 1;
  logic cmd_valid = 0, cmd_we = 0, wr_valid = 0, rd_ready = 0;
  logic [9:0] cmd_addr = 0;
  logic [10:0] cmd_len = 0;
  logic [31:0] wr_data = 0;
  logic cmd_ready, wr_ready, rd_valid, busy, done, CEB, WEB;
  logic [31:0] rd_data, D, Q;
  logic [9:0] A;

  logic [31:0] sram [NW];
  logic [31:0] ref_mem [NW];

  always #5 CLK = ~CLK;

  sram_burst_ctrl dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .Q(Q));

  always @(posedge CLK) if (!CEB) begin
    if (!WEB) sram[A] <= D;
    else Q <= sram[A];
  end

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int done_cnt = 0, done_cyc = -1, acc_cyc = -1, first_rv = -1, ceb_low = 0, outstanding = 0, viol = 0;
  bit busy_seen = 0;
  logic [31:0] rd_obs[$];
  int rd_cyc[$];
  int wa_obs[$];
  logic [31:0] wd_obs[$];
  int wr_cyc[$];

  always @(negedge CLK) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (rd_valid && first_rv < 0) first_rv = cyc;
    if (busy) busy_seen = 1;
    if (!CEB) ceb_low++;
    if (!CEB && !WEB) begin wa_obs.push_back(int'(A)); wd_obs.push_back(D); wr_cyc.push_back(cyc); end
    if (rd_valid && rd_ready) begin rd_obs.push_back(rd_data); rd_cyc.push_back(cyc); end
    if (RST) outstanding = 0;
    else begin
      // Issued-but-unconsumed words must never exceed the 2 storage slots.
      if (!CEB && WEB && (outstanding - int'(rd_valid && rd_ready)) >= 2) viol++;
      outstanding += int'(!CEB && WEB) - int'(rd_valid && rd_ready);
    end
  end

  int n_cmp = 0, n_bad = 0;
  bit tmo;
  logic [31:0] wq[$];
  int base16;

  task automatic clear_obs();
    rd_obs.delete(); rd_cyc.delete(); wa_obs.delete(); wd_obs.delete(); wr_cyc.delete();
    first_rv = -1; busy_seen = 0; viol = 0;
  endtask

  function automatic bit stream_bit(input int mode, input int k);
    bit [5:0] p;
    p = 6'b101001;
    case (mode)
      0: return 1'b1;
      1: return (k % 2) == 0;
      2: return 1'($urandom_range(0, 1));
      default: return (k < 6) ? p[k] : 1'b0;
    endcase
  endfunction

  task automatic run_burst(input bit we, input int addr, input int len, input int mode, input int stop_pops);
    int k, wi, d0;
    bit s;
    d0 = done_cnt; k = 0; wi = 0; tmo = 0;
    @(posedge CLK); #1;
    cmd_valid = 1; cmd_we = we; cmd_addr = addr[9:0]; cmd_len = len[10:0];
    @(posedge CLK); #1;
    cmd_valid = 0;
    while (done_cnt == d0) begin
      if (stop_pops > 0 && rd_obs.size() >= stop_pops) break;
      if (k > 400) begin tmo = 1; break; end
      s = stream_bit(mode, k);
      if (we) begin
        wr_valid = s && (wi < len) && (wi < wq.size());
        wr_data  = wr_valid ? wq[wi] : 32'h0;
      end else rd_ready = s;
      #1;
      if (wr_valid && wr_ready) wi++;
      @(posedge CLK); #1;
      k++;
    end
    wr_valid = 0; rd_ready = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    n_cmp++; if (CEB !== 1'b1 || WEB !== 1'b1) begin n_bad++; $display("FAIL reset_ceb_web got %b%b want 11", CEB, WEB); end
    n_cmp++; if (A !== 10'h0 || D !== 32'h0) begin n_bad++; $display("FAIL reset_a_d got %h/%h want 0/0", A, D); end
    RST = 0;
    idle(2);
  endtask

  task automatic test_wrap_write();
    int d0;
    clear_obs(); d0 = done_cnt;
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int i = 0; i < 4; i++) ref_mem[('h3FE + i) % NW] = wq[i];
    run_burst(1, 'h3FE, 4, 0, 0);
    idle(3);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL wrap_write_timeout got timeout want done"); end
    n_cmp++; if (wa_obs.size() != 4) begin n_bad++; $display("FAIL wrap_write_count got %0d want 4", wa_obs.size()); end
    for (int i = 0; i < 4 && i < wa_obs.size(); i++) begin
      n_cmp++; if (wa_obs[i] != ('h3FE + i) % NW || wd_obs[i] !== wq[i]) begin
        n_bad++; $display("FAIL wrap_write_%0d got %h:%h want %h:%h", i, wa_obs[i], wd_obs[i], ('h3FE + i) % NW, wq[i]); end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL wrap_write_done_cnt got %0d want 1", done_cnt - d0); end
    if (wr_cyc.size() == 4) begin
      n_cmp++; if (wr_cyc[3] != wr_cyc[0] + 3 || done_cyc != wr_cyc[3] + 1) begin
        n_bad++; $display("FAIL wrap_write_timing got %0d..%0d done %0d want consecutive, done +1", wr_cyc[0], wr_cyc[3], done_cyc); end
    end
  endtask

  task automatic test_wrap_read();
    int d0;
    clear_obs(); d0 = done_cnt;
    run_burst(0, 'h3FE, 4, 0, 0);
    idle(3);
    n_cmp++; if (rd_obs.size() != 4) begin n_bad++; $display("FAIL wrap_read_count got %0d want 4", rd_obs.size()); end
    for (int i = 0; i < 4 && i < rd_obs.size(); i++) begin
      n_cmp++; if (rd_obs[i] !== ref_mem[('h3FE + i) % NW] || rd_cyc[i] != acc_cyc + LAT + i) begin
        n_bad++; $display("FAIL wrap_read_%0d got %h@%0d want %h@%0d", i, rd_obs[i], rd_cyc[i],
                          ref_mem[('h3FE + i) % NW], acc_cyc + LAT + i); end
    end
    n_cmp++; if (first_rv != acc_cyc + LAT) begin n_bad++; $display("FAIL wrap_read_latency got %0d want %0d", first_rv - acc_cyc, LAT); end
    n_cmp++; if (done_cnt - d0 != 1 || (rd_cyc.size() == 4 && done_cyc <= rd_cyc[3])) begin
      n_bad++; $display("FAIL wrap_read_done got cnt %0d at %0d want 1 after last word", done_cnt - d0, done_cyc); end
  endtask

  task automatic test_zero_len();
    int d0, c0;
    clear_obs(); d0 = done_cnt; c0 = ceb_low;
    run_burst(1, $urandom_range(0, NW - 1), 0, 0, 0);
    idle(3);
    n_cmp++; if (done_cyc != acc_cyc + 1) begin n_bad++; $display("FAIL zero_len_done_cyc got %0d want %0d", done_cyc, acc_cyc + 1); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL zero_len_done_cnt got %0d want 1", done_cnt - d0); end
    n_cmp++; if (ceb_low != c0) begin n_bad++; $display("FAIL zero_len_ceb got %0d low cycles want 0", ceb_low - c0); end
    n_cmp++; if (busy_seen) begin n_bad++; $display("FAIL zero_len_busy got 1 want 0"); end
  endtask

  task automatic test_wr_pattern();
    int a, d0;
    int off[3];
    off = '{0, 3, 5};
    a = $urandom_range(0, NW - 1);
    clear_obs(); d0 = done_cnt;
    wq = '{$urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) ref_mem[(a + i) % NW] = wq[i];
    run_burst(1, a, 3, 3, 0);
    idle(3);
    n_cmp++; if (wa_obs.size() != 3) begin n_bad++; $display("FAIL wr_pattern_count got %0d want 3", wa_obs.size()); end
    for (int i = 0; i < 3 && i < wa_obs.size(); i++) begin
      n_cmp++; if (wa_obs[i] != (a + i) % NW || wd_obs[i] !== wq[i] || wr_cyc[i] != acc_cyc + 1 + off[i]) begin
        n_bad++; $display("FAIL wr_pattern_%0d got %h:%h@%0d want %h:%h@%0d", i, wa_obs[i], wd_obs[i], wr_cyc[i],
                          (a + i) % NW, wq[i], acc_cyc + 1 + off[i]); end
    end
    n_cmp++; if (done_cnt - d0 != 1 || (wr_cyc.size() == 3 && done_cyc != wr_cyc[2] + 1)) begin
      n_bad++; $display("FAIL wr_pattern_done got cnt %0d at %0d want 1 after 3rd write", done_cnt - d0, done_cyc); end
  endtask

  task automatic test_rd_stall();
    int d0;
    base16 = $urandom_range(0, NW - 1);
    wq.delete();
    for (int i = 0; i < 16; i++) begin wq.push_back($urandom); ref_mem[(base16 + i) % NW] = wq[i]; end
    clear_obs();
    run_burst(1, base16, 16, 0, 0);
    idle(2);
    n_cmp++; if (wa_obs.size() != 16) begin n_bad++; $display("FAIL rd_stall_fill got %0d want 16", wa_obs.size()); end
    clear_obs(); d0 = done_cnt;
    run_burst(0, base16, 8, 1, 0);
    idle(3);
    n_cmp++; if (rd_obs.size() != 8) begin n_bad++; $display("FAIL rd_stall_count got %0d want 8", rd_obs.size()); end
    for (int i = 0; i < 8 && i < rd_obs.size(); i++) begin
      n_cmp++; if (rd_obs[i] !== ref_mem[(base16 + i) % NW]) begin
        n_bad++; $display("FAIL rd_stall_%0d got %h want %h", i, rd_obs[i], ref_mem[(base16 + i) % NW]); end
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rd_stall_credit got %0d overflows want 0", viol); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL rd_stall_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    clear_obs(); d0 = done_cnt;
    run_burst(0, base16, 16, 0, 5);
    RST = 1;
    @(posedge CLK); #1;
    n_cmp++; if (CEB !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid_ceb_rv got %b%b want 10", CEB, rd_valid); end
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_busy_rdy got %b%b want 01", busy, cmd_ready); end
    RST = 0;
    idle(4);
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL reset_mid_done got %0d pulses want 0", done_cnt - d0); end
    n_cmp++; if (rd_obs.size() != 5) begin n_bad++; $display("FAIL reset_mid_count got %0d want 5", rd_obs.size()); end
    for (int i = 0; i < 5 && i < rd_obs.size(); i++) begin
      n_cmp++; if (rd_obs[i] !== ref_mem[(base16 + i) % NW]) begin
        n_bad++; $display("FAIL reset_mid_%0d got %h want %h", i, rd_obs[i], ref_mem[(base16 + i) % NW]); end
    end
  endtask

  task automatic test_random();
    int a, len;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 24);
      a = (it % 2 == 0) ? NW - $urandom_range(1, 12) : $urandom_range(0, NW - 1);
      wq.delete();
      for (int i = 0; i < len; i++) begin wq.push_back($urandom); ref_mem[(a + i) % NW] = wq[i]; end
      clear_obs();
      run_burst(1, a, len, 2, 0);
      idle(2);
      n_cmp++; if (tmo || wa_obs.size() != len) begin n_bad++; $display("FAIL rand_wr_count_%0d got %0d want %0d", it, wa_obs.size(), len); end
      for (int i = 0; i < len && i < wa_obs.size(); i++) begin
        n_cmp++; if (wa_obs[i] != (a + i) % NW || wd_obs[i] !== wq[i]) begin
          n_bad++; $display("FAIL rand_wr_%0d_%0d got %h:%h want %h:%h", it, i, wa_obs[i], wd_obs[i], (a + i) % NW, wq[i]); end
      end
      clear_obs();
      run_burst(0, a, len, 2, 0);
      idle(2);
      n_cmp++; if (tmo || rd_obs.size() != len) begin n_bad++; $display("FAIL rand_rd_count_%0d got %0d want %0d", it, rd_obs.size(), len); end
      for (int i = 0; i < len && i < rd_obs.size(); i++) begin
        n_cmp++; if (rd_obs[i] !== ref_mem[(a + i) % NW]) begin
          n_bad++; $display("FAIL rand_rd_%0d_%0d got %h want %h", it, i, rd_obs[i], ref_mem[(a + i) % NW]); end
      end
      n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rand_rd_credit_%0d got %0d overflows want 0", it, viol); end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_write();
    test_wrap_read();
    test_zero_len();
    test_wr_pattern();
    test_rd_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want finish before 1ms");
    $fatal(1);
  end
endmodule
